// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter.
//   state_t    : transmitter FSM state encoding
//   DATA_BITS  : data bits per frame (8N1)
//   STOP_BITS  : stop bits per frame
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each
// bit period with a one-cycle tick. A clear forces the count back to 0.
//   clk, rst : system clock, async active-high reset
//   clear    : restart the bit period (count -> 0)
//   enable   : advance the count this cycle
//   tick     : high on the final cycle of a bit period
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Not gated by clear: clear is derived from the FSM next state, which
    // itself depends on tick.
    assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pulls bytes from an upstream FIFO.
//   clk, rst     : system clock, async active-high reset
//   enable       : allows a new frame to start (checked in IDLE / end of STOP)
//   fifo_empty   : upstream FIFO empty flag
//   fifo_data    : upstream FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : one-cycle read strobe per frame
//   tx           : serial output, idle high, LSB first
//   busy         : high whenever not IDLE
//   frames_sent  : completed frame count, wraps at 256
//
// state | meaning
// IDLE  | line idle high, waiting for enable with data available
// REQ   | read strobe to FIFO (single cycle)
// LOAD  | FIFO data becomes valid; captured into shift register at exit
// START | start bit (tx=0) for one bit period
// DATA  | shift register LSB on tx, 8 bit periods
// STOP  | stop bit (tx=1); frame counted on its last cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    state_t                 r_state;
    state_t                 w_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_bit_idx;
    logic                   w_tick;
    logic                   w_cnt_en;
    logic                   w_clear;
    logic                   w_can_start;

    assign w_can_start = enable && !fifo_empty;
    assign w_clear     = (w_next != r_state);

    baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (w_cnt_en),
        .tick   (w_tick)
    );

    always_comb begin
        w_next     = r_state;
        fifo_rd_en = 1'b0;
        tx         = 1'b1;
        busy       = 1'b1;
        w_cnt_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_can_start) w_next = ST_REQ;
            end
            ST_REQ: begin
                fifo_rd_en = 1'b1;
                w_next     = ST_LOAD;
            end
            ST_LOAD: begin
                w_next = ST_START;
            end
            ST_START: begin
                tx       = 1'b0;
                w_cnt_en = 1'b1;
                if (w_tick) w_next = ST_DATA;
            end
            ST_DATA: begin
                tx       = r_shift[0];
                w_cnt_en = 1'b1;
                if (w_tick && (r_bit_idx == 3'(DATA_BITS - 1))) w_next = ST_STOP;
            end
            ST_STOP: begin
                w_cnt_en = 1'b1;
                if (w_tick && (r_bit_idx == 3'(STOP_BITS - 1))) begin
                    w_next = w_can_start ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            frames_sent <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == ST_LOAD) begin
                r_shift <= fifo_data;
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_shift <= r_shift >> 1;
            end

            // Bit index counts periods within DATA and within STOP.
            if (w_clear) begin
                r_bit_idx <= '0;
            end else if (w_tick) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if ((r_state == ST_STOP) && w_clear) begin
                frames_sent <= frames_sent + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic [7:0] frames_sent;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rd_en  (fifo_rd_en),
        .tx          (tx),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int         rd_cnt = 0;
    int         frames_rx = 0;
    int         gap_cnt = 999;
    int         last_gap = 0;
    int         mon_phase = 0;
    int         mon_cnt = 0;
    int         mon_b = 0;
    logic       mon_last_tx = 1'b1;
    logic       mon_bad = 1'b0;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] mon_exp = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Upstream FIFO model: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd_en && (fifo_q.size() > 0)) fifo_data <= fifo_q.pop_front();
    end

    always @(negedge clk) begin
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic push_fifo(input logic [7:0] b);
        fifo_q.push_back(b);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
    endtask

    // Monitor: decodes tx at negedges, checks bit widths and data against
    // the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_phase   = 0;
                mon_last_tx = 1'b1;
                gap_cnt     = 999;
                rd_cnt      = 0;
                frames_rx   = 0;
            end else begin
                if (fifo_rd_en) rd_cnt++;
                if (mon_phase == 0) begin
                    if (tx === 1'b0 && mon_last_tx === 1'b1) begin
                        mon_phase = 1;
                        mon_cnt   = 0;
                        mon_byte  = 8'h00;
                        mon_bad   = 1'b0;
                        last_gap  = gap_cnt;
                    end else if (gap_cnt < 999) begin
                        gap_cnt++;
                    end
                end
                if (mon_phase == 1) begin
                    mon_b = mon_cnt / CPB;
                    if (mon_b == 0) begin
                        if (tx !== 1'b0) mon_bad = 1'b1;
                    end else if (mon_b <= 8) begin
                        if (mon_cnt % CPB == 0) mon_byte[mon_b-1] = tx;
                        else if (tx !== mon_byte[mon_b-1]) mon_bad = 1'b1;
                    end else begin
                        if (tx !== 1'b1) mon_bad = 1'b1;
                    end
                    if (mon_cnt == 10*CPB - 1) begin
                        check("frame_shape", mon_bad, 0);
                        check("frame_was_expected", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) begin
                            mon_exp = exp_q.pop_front();
                            check("frame_data", mon_byte, mon_exp);
                        end
                        frames_rx++;
                        mon_phase = 0;
                        gap_cnt   = 0;
                    end else begin
                        mon_cnt++;
                    end
                end
                mon_last_tx = tx;
            end
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_rx < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (frames_rx < n) check("frame_timeout", frames_rx, n);
    endtask

    task automatic wait_rd(input int n, input int budget);
        int k;
        k = 0;
        while (rd_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (rd_cnt < n) check("rd_timeout", rd_cnt, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("leftover_expected", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int k;

        // Reset values
        #1 rst = 1'b1;
        #2;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_frames", frames_sent, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Empty FIFO with enable high
        enable = 1'b1;
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("empty_idle_violations", viol, 0);
        check("empty_rd_count", rd_cnt, 0);

        // Single byte 0xA5
        push_fifo(8'hA5);
        expect_byte(8'hA5);
        wait_rd(1, 20);
        repeat (5) @(negedge clk);
        check("single_busy_mid", busy, 1);
        wait_frames(1, 100);
        repeat (5) @(negedge clk);
        check("single_frames", frames_sent, 1);
        check("single_rd_count", rd_cnt, 1);
        check("single_busy_end", busy, 0);

        // Back-to-back 0x00, 0xFF
        do_reset();
        push_fifo(8'h00);
        push_fifo(8'hFF);
        expect_byte(8'h00);
        expect_byte(8'hFF);
        wait_frames(2, 200);
        repeat (5) @(negedge clk);
        check("b2b_gap", last_gap, 2);
        check("b2b_frames", frames_sent, 2);
        check("b2b_rd_count", rd_cnt, 2);

        // Enable drop during DATA of the first frame
        do_reset();
        push_fifo(8'h3C);
        push_fifo(8'h81);
        push_fifo(8'h42);
        expect_byte(8'h3C);
        wait_rd(1, 20);
        repeat (12) @(negedge clk);
        check("drop_busy_in_frame", busy, 1);
        enable = 1'b0;
        wait_frames(1, 100);
        repeat (20) @(negedge clk);
        check("drop_rd_count", rd_cnt, 1);
        check("drop_busy", busy, 0);
        check("drop_frames", frames_sent, 1);
        check("drop_fifo_left", fifo_q.size(), 2);

        // Reset during the bit-3 period (0xA5 bit 3 is 0, so tx is low)
        fifo_q.delete();
        @(negedge clk);
        enable = 1'b1;
        push_fifo(8'hA5);
        k = 0;
        while (!(mon_phase == 1 && mon_cnt >= 17) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("midrst_reached_bit3", (mon_phase == 1 && mon_cnt >= 17 && mon_cnt <= 19), 1);
        check("midrst_tx_before", tx, 0);
        rst = 1'b1;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_frames", frames_sent, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_fifo(8'hC3);
        expect_byte(8'hC3);
        wait_frames(1, 100);
        repeat (5) @(negedge clk);
        check("midrst_after_frames", frames_sent, 1);

        // Frame counter wrap
        do_reset();
        for (int i = 0; i < 256; i++) begin
            k = 0;
            while (fifo_q.size() >= 8 && k < 2000) begin
                @(negedge clk);
                k++;
            end
            push_fifo(8'(i));
            expect_byte(8'(i));
        end
        wait_frames(255, 2000);
        @(posedge clk);
        #1;
        check("wrap_frames_255", frames_sent, 255);
        wait_frames(256, 200);
        @(posedge clk);
        #1;
        check("wrap_frames_0", frames_sent, 0);
        repeat (10) @(negedge clk);
        check("wrap_rd_count", rd_cnt, 256);
        check("wrap_busy_end", busy, 0);

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  permits new frames to start; sampled only in IDLE and at the end of STOP.
REQ-005 fifo_empty  input  1  empty flag of the upstream 8-entry FIFO.
REQ-006 fifo_data  input  8  upstream FIFO read data; valid one cycle after a read strobe.
REQ-007 fifo_rd_en  output  1  read strobe to the upstream FIFO; exactly one cycle per frame.
REQ-008 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 frames_sent  output  8  count of completed frames; wraps 255 -> 0.

Function
REQ-011 The FSM SHALL have states IDLE, REQ, LOAD, START, DATA and STOP.
REQ-012 In IDLE, if enable=1 and fifo_empty=0, the next state SHALL be REQ; otherwise the FSM SHALL stay in IDLE.
REQ-013 fifo_rd_en SHALL be high only during the single REQ cycle; it is a Moore output.
REQ-014 REQ SHALL always go to LOAD after 1 cycle.
REQ-015 At the end of LOAD, the shift register SHALL capture fifo_data and the FSM SHALL go to START.
REQ-016 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-017 DATA SHALL drive the shift register LSB onto tx for 8 bit periods of CLKS_PER_BIT cycles each, shifting right at each bit boundary.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles.
REQ-019 frames_sent SHALL increment on the last STOP cycle.
REQ-020 At the end of STOP, the next state SHALL be REQ if enable=1 and fifo_empty=0, else IDLE.
REQ-021 Back-to-back frames SHALL therefore carry exactly 2 idle-high cycles (REQ, LOAD) between the stop bit and the next start bit.
REQ-022 tx SHALL be 1 in IDLE, REQ and LOAD.
REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame; the current frame completes and no further frame starts.
REQ-024 fifo_empty SHALL be ignored outside IDLE and the STOP exit decision.
REQ-025 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at every state change.
REQ-026 The bit index SHALL be 3 bits; DATA SHALL exit after index 7 completes.

Reset
REQ-027 Asserting rst SHALL immediately force the following, independent of clk, including mid-frame: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frames_sent=0, counters=0, shift register=0.
REQ-028 After rst deasserts, the first frame SHALL begin no earlier than the first rising edge at which the IDLE condition of REQ-012 holds.

Structure
REQ-029 The state encodings and frame constants (data bits=8, stop bits=1) SHALL live in the shared package uart_pkg.
REQ-030 The bit-period counter SHALL be one sub-module, baud_counter, with inputs clear and enable and a one-cycle tick output.
REQ-031 The FSM and shift register SHALL remain in fifo_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-032 Single byte: FIFO holds 0xA5, enable=1 -> one fifo_rd_en pulse, then tx carries 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 cycles (40-cycle frame), and frames_sent=1.
REQ-033 Back-to-back: FIFO holds 0x00 and 0xFF -> two frames with exactly 2 high cycles between the first stop bit and the second start bit, and frames_sent=2.
REQ-034 Empty FIFO: enable=1, fifo_empty=1 for 100 cycles -> fifo_rd_en never asserts, tx=1, busy=0.
REQ-035 Enable drop: enable falls during DATA of frame 1 while the FIFO still holds bytes -> frame 1 completes, no second fifo_rd_en, FSM returns to IDLE.
REQ-036 Reset mid-frame: rst pulses during the bit-3 period -> tx=1, busy=0 and frames_sent=0 within the same cycle; a fresh full frame follows after release.
REQ-037 Counter wrap: send 256 frames -> frames_sent reads 0 after the 256th frame.
